// File: rtl/relogio_bcd_param.sv
`default_nettype none
// ============================================================================
// Module   : relogio_bcd_param
// Purpose  : BCD time-of-day clock with a prescaler, 12h/24h display, validated load and strobes.
//            Optional alarm is built when RELOGIO_ALARM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module relogio_bcd_param #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRE_W         = $clog2(TICKS_PER_SEC) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
`ifdef RELOGIO_ALARM_EN
    input  logic       alarm_set,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic       alarm,
`endif
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       load_err
);

    localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    logic [PRE_W-1:0] r_pre;
    logic [7:0]       r_hh;
    logic [7:0]       r_mm;
    logic [7:0]       r_ss;
    logic             r_sec_pulse;
    logic             r_day_pulse;
    logic             r_load_err;

    logic [7:0]       w_hh_nx;
    logic [7:0]       w_mm_nx;
    logic [7:0]       w_ss_nx;
    logic             w_day_wrap;
    logic             w_tick_due;
    logic             w_tick_fire;
    logic             w_load_ok;
    logic             w_aset_err;
    logic [4:0]       w_hh_bin;
    logic [4:0]       w_hh_12;
    logic [7:0]       w_hh_12_bcd;

    function automatic logic digit_ok(input logic [7:0] v, input logic [3:0] max_tens);
        return (v[3:0] <= 4'd9) && (v[7:4] <= max_tens);
    endfunction

    function automatic logic hour_ok(input logic [7:0] v);
        return digit_ok(v, 4'd2) && (v <= 8'h23);
    endfunction

    assign w_load_ok   = hour_ok(set_hh) && digit_ok(set_mm, 4'd5) && digit_ok(set_ss, 4'd5);
    assign w_tick_due  = (r_pre == c_PRE_LAST);
    assign w_tick_fire = en && !load && w_tick_due;

    // Ripple-carry through the six BCD digits; hours roll over only at 23.
    always_comb begin
        w_ss_nx    = r_ss;
        w_mm_nx    = r_mm;
        w_hh_nx    = r_hh;
        w_day_wrap = 1'b0;
        if (r_ss[3:0] != 4'd9) begin
            w_ss_nx[3:0] = r_ss[3:0] + 4'd1;
        end else begin
            w_ss_nx[3:0] = 4'd0;
            if (r_ss[7:4] != 4'd5) begin
                w_ss_nx[7:4] = r_ss[7:4] + 4'd1;
            end else begin
                w_ss_nx[7:4] = 4'd0;
                if (r_mm[3:0] != 4'd9) begin
                    w_mm_nx[3:0] = r_mm[3:0] + 4'd1;
                end else begin
                    w_mm_nx[3:0] = 4'd0;
                    if (r_mm[7:4] != 4'd5) begin
                        w_mm_nx[7:4] = r_mm[7:4] + 4'd1;
                    end else begin
                        w_mm_nx[7:4] = 4'd0;
                        if (r_hh == 8'h23) begin
                            w_hh_nx    = 8'h00;
                            w_day_wrap = 1'b1;
                        end else if (r_hh[3:0] == 4'd9) begin
                            w_hh_nx[3:0] = 4'd0;
                            w_hh_nx[7:4] = r_hh[7:4] + 4'd1;
                        end else begin
                            w_hh_nx[3:0] = r_hh[3:0] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre       <= '0;
            r_hh        <= 8'h00;
            r_mm        <= 8'h00;
            r_ss        <= 8'h00;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_load_err  <= (load && !w_load_ok) || w_aset_err;
            // A load, valid or not, pre-empts the prescaler for this cycle.
            if (load) begin
                if (w_load_ok) begin
                    r_hh  <= set_hh;
                    r_mm  <= set_mm;
                    r_ss  <= set_ss;
                    r_pre <= '0;
                end
            end else if (en) begin
                if (w_tick_due) begin
                    r_pre       <= '0;
                    r_hh        <= w_hh_nx;
                    r_mm        <= w_mm_nx;
                    r_ss        <= w_ss_nx;
                    r_sec_pulse <= 1'b1;
                    r_day_pulse <= w_day_wrap;
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
            end
        end
    end

`ifdef RELOGIO_ALARM_EN
    logic [7:0] r_alarm_hh;
    logic [7:0] r_alarm_mm;
    logic       r_armed;
    logic       r_alarm;
    logic       w_aset_ok;

    assign w_aset_ok  = hour_ok(alarm_hh) && digit_ok(alarm_mm, 4'd5);
    assign w_aset_err = alarm_set && !w_aset_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alarm_hh <= 8'h00;
            r_alarm_mm <= 8'h00;
            r_armed    <= 1'b0;
            r_alarm    <= 1'b0;
        end else if (alarm_set && w_aset_ok) begin
            r_alarm_hh <= alarm_hh;
            r_alarm_mm <= alarm_mm;
            r_armed    <= 1'b1;
            r_alarm    <= 1'b0;
        end else if (w_tick_fire && r_armed &&
                     ({w_hh_nx, w_mm_nx, w_ss_nx} == {r_alarm_hh, r_alarm_mm, 8'h00})) begin
            r_alarm <= 1'b1;
        end
    end

    assign alarm = r_alarm;
`else
    assign w_aset_err = 1'b0;
`endif

    // 12h view: 0 -> 12, 13..23 -> 1..11; the stored hour is always 24h.
    assign w_hh_bin = (5'(r_hh[7:4]) * 5'd10) + 5'(r_hh[3:0]);

    always_comb begin
        w_hh_12 = w_hh_bin;
        if (w_hh_bin == 5'd0) begin
            w_hh_12 = 5'd12;
        end else if (w_hh_bin > 5'd12) begin
            w_hh_12 = w_hh_bin - 5'd12;
        end
        if (w_hh_12 >= 5'd10) begin
            w_hh_12_bcd = {4'd1, 4'(w_hh_12 - 5'd10)};
        end else begin
            w_hh_12_bcd = {4'd0, w_hh_12[3:0]};
        end
    end

    assign hh_bcd    = mode_12h ? w_hh_12_bcd : r_hh;
    assign pm        = mode_12h && (r_hh >= 8'h12);
    assign mm_bcd    = r_mm;
    assign ss_bcd    = r_ss;
    assign sec_pulse = r_sec_pulse;
    assign day_pulse = r_day_pulse;
    assign load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_relogio_bcd_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_relogio_bcd_param
// Purpose  : Scoreboard bench for relogio_bcd_param using a seconds-of-day reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relogio_bcd_param;

    localparam int T = 4;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic       sec;
        logic       day;
        logic       err;
        logic       alrm;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       mode_12h = 1'b0;
    logic       load = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
    logic [7:0] hh_bcd;
    logic [7:0] mm_bcd;
    logic [7:0] ss_bcd;
    logic       pm;
    logic       sec_pulse;
    logic       day_pulse;
    logic       load_err;
    logic       alarm_w;
`ifdef RELOGIO_ALARM_EN
    logic       alarm_set = 1'b0;
    logic [7:0] alarm_hh = 8'h00;
    logic [7:0] alarm_mm = 8'h00;
`else
    assign alarm_w = 1'b0;
`endif

    relogio_bcd_param #(.TICKS_PER_SEC(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode_12h  (mode_12h),
        .load      (load),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .set_ss    (set_ss),
`ifdef RELOGIO_ALARM_EN
        .alarm_set (alarm_set),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm     (alarm_w),
`endif
        .hh_bcd    (hh_bcd),
        .mm_bcd    (mm_bcd),
        .ss_bcd    (ss_bcd),
        .pm        (pm),
        .sec_pulse (sec_pulse),
        .day_pulse (day_pulse),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    obs_t expq[$];

    // Staged stimulus, applied on the next falling edge by cyc().
    bit       s_rst = 1'b1, s_en = 1'b0, s_mode = 1'b0, s_load = 1'b0, s_aset = 1'b0;
    bit [7:0] s_hh = 0, s_mm = 0, s_ss = 0, s_ahh = 0, s_amm = 0;

    // Reference model: time as seconds-of-day, prescaler as a plain count.
    int m_sod = 0, m_pre = 0, m_alarm_sod = 0;
    bit m_armed = 1'b0, m_alarm = 1'b0;

    function automatic int bcd2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int x);
        logic [7:0] r;
        r[7:4] = 4'(x / 10);
        r[3:0] = 4'(x % 10);
        return r;
    endfunction

    function automatic bit bcd_valid(input logic [7:0] v, input int lim);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (bcd2i(v) < lim);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        obs_t e;
        int   h;
        e = '0;
        @(negedge clk);
        reset    = s_rst;
        en       = s_en;
        mode_12h = s_mode;
        load     = s_load;
        set_hh   = s_hh;
        set_mm   = s_mm;
        set_ss   = s_ss;
`ifdef RELOGIO_ALARM_EN
        alarm_set = s_aset;
        alarm_hh  = s_ahh;
        alarm_mm  = s_amm;
`endif
        if (s_rst) begin
            m_sod = 0; m_pre = 0; m_armed = 0; m_alarm = 0; m_alarm_sod = 0;
        end else begin
            if (s_load) begin
                if (bcd_valid(s_hh, 24) && bcd_valid(s_mm, 60) && bcd_valid(s_ss, 60)) begin
                    m_sod = bcd2i(s_hh) * 3600 + bcd2i(s_mm) * 60 + bcd2i(s_ss);
                    m_pre = 0;
                end else begin
                    e.err = 1'b1;
                end
            end else if (s_en) begin
                if (m_pre == T - 1) begin
                    m_pre = 0;
                    m_sod = (m_sod + 1) % 86400;
                    e.sec = 1'b1;
                    e.day = (m_sod == 0);
                    if (m_armed && m_sod == m_alarm_sod) m_alarm = 1'b1;
                end else begin
                    m_pre++;
                end
            end
`ifdef RELOGIO_ALARM_EN
            if (s_aset) begin
                if (bcd_valid(s_ahh, 24) && bcd_valid(s_amm, 60)) begin
                    m_alarm_sod = bcd2i(s_ahh) * 3600 + bcd2i(s_amm) * 60;
                    m_armed = 1'b1;
                    m_alarm = 1'b0;
                end else begin
                    e.err = 1'b1;
                end
            end
`endif
        end
        h    = m_sod / 3600;
        e.hh = s_mode ? i2bcd((h % 12 == 0) ? 12 : h % 12) : i2bcd(h);
        e.pm = s_mode && (h >= 12);
        e.mm = i2bcd((m_sod / 60) % 60);
        e.ss = i2bcd(m_sod % 60);
        e.alrm = m_alarm;
        expq.push_back(e);
        s_load = 1'b0;
        s_aset = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        s_load = 1'b1; s_hh = h; s_mm = m; s_ss = s;
        cyc();
    endtask

    // Monitor: one expectation per clock edge, sampled just after it.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a = {hh_bcd, mm_bcd, ss_bcd, pm, sec_pulse, day_pulse, load_err, alarm_w};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL obs t=%0t got hh=%h mm=%h ss=%h pm=%b sec=%b day=%b err=%b al=%b exp hh=%h mm=%h ss=%h pm=%b sec=%b day=%b err=%b al=%b",
                             $time, a.hh, a.mm, a.ss, a.pm, a.sec, a.day, a.err, a.alrm,
                             e.hh, e.mm, e.ss, e.pm, e.sec, e.day, e.err, e.alrm);
                end
            end
        end
    end

    initial begin
        logic [7:0] v;
        int         sod;
        #1;
        chk("rst_hh", 32'(hh_bcd), 32'h00);
        chk("rst_mm", 32'(mm_bcd), 32'h00);
        chk("rst_ss", 32'(ss_bcd), 32'h00);
        chk("rst_strobes", {29'd0, sec_pulse, day_pulse, load_err}, 32'd0);
        mode_12h = 1'b1;
        #1;
        chk("rst_hh_12h", 32'(hh_bcd), 32'h12);
        chk("rst_pm_12h", 32'(pm), 32'd0);
        mode_12h = 1'b0;

        s_rst = 1'b1; cyc();
        s_rst = 1'b0; s_en = 1'b1;
        repeat (245) cyc();

        do_load(8'h23, 8'h59, 8'h58);
        repeat (10) cyc();

        // Rejected loads, with the counter both stopped and running.
        s_en = 1'b0;
        do_load(8'h24, 8'h10, 8'h00);
        do_load(8'h12, 8'h5A, 8'h00);
        do_load(8'h12, 8'h00, 8'h60);
        do_load(8'h1A, 8'h00, 8'h00);
        s_en = 1'b1;
        cyc();
        do_load(8'h24, 8'h00, 8'h00);
        repeat (3) cyc();

        // Load on the exact cycle a tick would have happened.
        for (int i = 0; i < T && m_pre != T - 1; i++) cyc();
        do_load(8'h10, 8'h20, 8'h30);
        repeat (6) cyc();

        s_mode = 1'b1;
        do_load(8'h00, 8'h30, 8'h00); repeat (3) cyc();
        do_load(8'h12, 8'h00, 8'h00); repeat (3) cyc();
        do_load(8'h13, 8'h05, 8'h00); repeat (3) cyc();
        do_load(8'h23, 8'h59, 8'h00);
        for (int i = 0; i < 12; i++) begin
            s_mode = i[0];
            cyc();
        end
        s_mode = 1'b0;

        do_load(8'h01, 8'h02, 8'h03);
        repeat (2) cyc();
        s_en = 1'b0; repeat (10) cyc();
        s_en = 1'b1; repeat (6) cyc();

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_hh", 32'(hh_bcd), 32'h00);
        chk("async_mm", 32'(mm_bcd), 32'h00);
        chk("async_ss", 32'(ss_bcd), 32'h00);
        chk("async_strobes", {29'd0, sec_pulse, day_pulse, load_err}, 32'd0);
        s_rst = 1'b1; cyc();
        s_rst = 1'b0; cyc();

`ifdef RELOGIO_ALARM_EN
        s_aset = 1'b1; s_ahh = 8'h00; s_amm = 8'h01;
        do_load(8'h00, 8'h00, 8'h58);
        repeat (12) cyc();
        s_aset = 1'b1; s_ahh = 8'h25; s_amm = 8'h00; cyc();
        repeat (3) cyc();
        s_aset = 1'b1; s_ahh = 8'h05; s_amm = 8'h00; cyc();
        do_load(8'h05, 8'h00, 8'h00);
        repeat (6) cyc();
`endif

        repeat (3000) begin
            s_en   = ($urandom_range(0, 9) != 0);
            s_mode = $urandom_range(0, 1);
            s_rst  = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 29) == 0) begin
                s_load = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    v = 8'($urandom_range(0, 255)); s_hh = v;
                    v = 8'($urandom_range(0, 255)); s_mm = v;
                    v = 8'($urandom_range(0, 255)); s_ss = v;
                end else begin
                    sod = ($urandom_range(0, 1) == 0) ? 86400 - int'($urandom_range(1, 4))
                                                       : int'($urandom_range(0, 86399));
                    s_hh = i2bcd(sod / 3600);
                    s_mm = i2bcd((sod / 60) % 60);
                    s_ss = i2bcd(sod % 60);
                end
            end
            if ($urandom_range(0, 99) == 0) begin
                s_aset = 1'b1;
                s_ahh  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                      : i2bcd(int'($urandom_range(0, 23)));
                s_amm  = i2bcd(int'($urandom_range(0, 59)));
            end
            cyc();
        end
        s_rst = 1'b0;
        cyc();

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/relogio_bcd_param.md
Name: relogio_bcd_param

Overview:
Parametrised successor to the team's 24h BCD clock.
- Keeps hours, minutes and seconds as packed BCD, driven from the system clock through an internal prescaler. It does not use rippled counter clocks.
- Adds a runtime 12h/24h display mode, validated time load, an enable, and one-cycle second and day strobes.
- Sits between the board clock and the 7-segment display driver.
- Fully synchronous except for the asynchronous reset.

Parameters:
- TICKS_PER_SEC, default 50000000: clk cycles per second tick. Must be >= 1. A value of 1 means one tick per enabled cycle.
- PRE_W, default $clog2(TICKS_PER_SEC)+1: prescaler width. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  count enable; when 0, prescaler and time hold.
- mode_12h  in  1  display mode: 0 = 24h, 1 = 12h with pm flag. Affects outputs only.
- load  in  1  one-cycle request to load set_* values.
- set_hh  in  8  BCD hours, always 24h format, 00-23.
- set_mm  in  8  BCD minutes, 00-59.
- set_ss  in  8  BCD seconds, 00-59.
- hh_bcd  out  8  displayed hours, BCD.
- mm_bcd  out  8  minutes, BCD.
- ss_bcd  out  8  seconds, BCD.
- pm  out  1  1 when 12h mode and internal hour >= 12; 0 in 24h mode.
- sec_pulse  out  1  one-cycle strobe on each second increment.
- day_pulse  out  1  one-cycle strobe when time wraps 23:59:59 -> 00:00:00.
- load_err  out  1  one-cycle strobe when a load is rejected.

Behaviour:

Reset:
- Internal time is 00:00:00, prescaler is 0.
- sec_pulse, day_pulse and load_err are 0.
- Outputs are hh_bcd=00 in 24h mode or 12 in 12h mode, with pm=0.

Prescaler:
- While en=1, it counts 0..TICKS_PER_SEC-1 and wraps to 0.
- The tick is the cycle on which the prescaler holds TICKS_PER_SEC-1 with en=1.
- On that tick's edge the seconds increment and sec_pulse is registered high for the following cycle.

Counting, per BCD digit:
- Units count 0-9. Seconds and minutes tens count 0-5.
- ss 59 -> 00 carries into mm. mm 59 -> 00 carries into hh.
- hh 23 -> 00: day_pulse is high in the same cycle that sec_pulse shows 00:00:00.
- hh units wrap at 9, except when the tens digit is 2, where they wrap at 3.

Enable:
- en=0 freezes the prescaler and time; no strobes are generated.
- Re-asserting en resumes from the frozen prescaler value.

Load:
- load=1 with valid data: the next edge writes the set values and clears the prescaler to 0. The first tick after a load comes TICKS_PER_SEC enabled cycles later.
- Data is invalid if any nibble > 9, set_hh > 0x23, or set_mm/set_ss tens > 5.
- Invalid data: time and prescaler are unchanged and load_err is high for one cycle.
- load has priority over a tick in the same cycle: the tick is lost and no sec_pulse or day_pulse is generated.
- load works regardless of en.

Display mapping:
- Combinational from internal hours; mode_12h may toggle at any time with no effect on timekeeping.
- In 12h mode: 00 -> 12 with pm=0; 01-11 -> same with pm=0; 12 -> 12 with pm=1; 13-23 -> 01-11 with pm=1.
- mm_bcd and ss_bcd are unaffected by mode.

Reset mid-operation:
- Clears all state immediately, independent of clk, including pending strobes.

Optional Feature:
Macro RELOGIO_ALARM_EN.

When defined, the block gains four ports:
- alarm_set  in  1  one-cycle request to latch the alarm time.
- alarm_hh  in  8  BCD alarm hours, 24h.
- alarm_mm  in  8  BCD alarm minutes.
- alarm  out  1  alarm flag.

Behaviour with the macro:
- alarm_set latches the alarm time and arms it. The same validation as load applies; invalid values pulse load_err and leave the alarm unchanged.
- alarm sets on the tick edge where the new time equals alarm_hh:alarm_mm:00.
- alarm is sticky until alarm_set or reset.
- A load that lands exactly on the alarm time does not trigger the alarm.
- Reset clears and disarms the alarm.

When the macro is undefined, the ports and logic are absent.

Test Plan (TICKS_PER_SEC=4):
1. Reset, then en=1 for 4 cycles -> ss_bcd=01 and sec_pulse high for exactly 1 cycle; after 240 enabled cycles, mm=01 ss=00.
2. Load 23:59:58, en=1, wait 8 cycles -> 00:00:00, with day_pulse and sec_pulse both high in the same single cycle.
3. Load set_hh=0x24, then set_mm=0x5A -> load_err pulses once each and time is unchanged. Load coincident with a tick -> set value appears, no sec_pulse.
4. mode_12h=1 with internal 00:30, 12:00, 13:05, 23:59 -> hh/pm = 12/0, 12/1, 01/1, 11/1. mm is unchanged and toggling mode does not disturb counting.
5. en=0 after 2 prescaler cycles for 10 cycles, then en=1 -> tick arrives after 2 more enabled cycles. Reset asserted between edges -> outputs are 00:00:00 before the next clk edge.
6. (RELOGIO_ALARM_EN) Alarm 00:01, from 00:00:58 -> alarm rises 8 cycles later and stays high until alarm_set.
